// File: rtl/bcd_gate_counter.sv
// Gated N-digit BCD event counter for the frequency meter.
// Counts rising edges of sigin while w_enable is high, wraps or saturates past all-9s,
// and on gate close latches the final count into a hold register with a one-cycle
// valid pulse. The held result stays readable while the next window counts.
module bcd_gate_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  sigin,
  input  logic                  clear,
  input  logic                  w_enable,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   latch_bcd,
  output logic                  latch_ovf,
  output logic                  latch_valid
);

  localparam int unsigned W = 4 * DIGITS;

  // Gate phase seen on the current edge, decoded from the gate and its delayed copy.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StCount,
    StClose
  } phase_e;

  phase_e phase;

  logic           en_d;
  logic [W-1:0]   count_q, count_d, count_inc;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   latch_q, latch_d;
  logic           latch_ovf_q, latch_ovf_d;
  logic           valid_q, valid_d;
  logic [DIGITS:0] carry;
  logic           all_nines;

  // Classify the edge by comparing the current gate with the previous one.
  always_comb begin
    unique case ({w_enable, en_d})
      2'b10:   phase = StStart;
      2'b11:   phase = StCount;
      2'b01:   phase = StClose;
      default: phase = StIdle;
    endcase
  end

  // Ripple BCD increment: a digit advances only when every lower digit is 9.
  always_comb begin
    carry     = '0;
    count_inc = '0;
    carry[0]  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry[i]) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
          carry[i+1]          = 1'b1;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
        end
      end else begin
        count_inc[4*i +: 4] = count_q[4*i +: 4];
      end
    end
  end

  // Carry out of the top digit means the count was all-9s before this increment.
  assign all_nines = carry[DIGITS];

  // Next-state for count, overflow and the hold register.
  always_comb begin
    count_d     = count_q;
    ovf_d       = ovf_q;
    latch_d     = latch_q;
    latch_ovf_d = latch_ovf_q;
    valid_d     = 1'b0;
    unique case (phase)
      StStart: begin
        // The opening edge is itself counted.
        count_d = {{(W-1){1'b0}}, 1'b1};
        ovf_d   = 1'b0;
      end
      StCount: begin
        if (all_nines) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? count_q : count_inc;
        end else begin
          count_d = count_inc;
        end
      end
      StClose: begin
        latch_d     = count_q;
        latch_ovf_d = ovf_q;
        valid_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers; clear wins over every gate phase, including a pending latch.
  always_ff @(posedge sigin) begin
    if (clear) begin
      en_d        <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      latch_q     <= '0;
      latch_ovf_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      en_d        <= w_enable;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      latch_q     <= latch_d;
      latch_ovf_q <= latch_ovf_d;
      valid_q     <= valid_d;
    end
  end

  assign count_bcd   = count_q;
  assign overflow    = ovf_q;
  assign latch_bcd   = latch_q;
  assign latch_ovf   = latch_ovf_q;
  assign latch_valid = valid_q;

endmodule

// File: tb/tb_bcd_gate_counter.sv
// Self-checking bench: three counter variants (4-digit wrap, 4-digit saturate, 1-digit
// wrap) share one stimulus; a window-level edge-count model predicts all outputs.
module tb_bcd_gate_counter;

  logic sigin = 1'b0;
  logic clear = 1'b1;
  logic w_enable = 1'b0;

  always #5 sigin = ~sigin;

  logic [15:0] cnt_a, lat_a, cnt_b, lat_b;
  logic [3:0]  cnt_c, lat_c;
  logic        ovf_a, lovf_a, lv_a, ovf_b, lovf_b, lv_b, ovf_c, lovf_c, lv_c;

  bcd_gate_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .sigin(sigin), .clear(clear), .w_enable(w_enable),
    .count_bcd(cnt_a), .overflow(ovf_a), .latch_bcd(lat_a), .latch_ovf(lovf_a),
    .latch_valid(lv_a)
  );

  bcd_gate_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .sigin(sigin), .clear(clear), .w_enable(w_enable),
    .count_bcd(cnt_b), .overflow(ovf_b), .latch_bcd(lat_b), .latch_ovf(lovf_b),
    .latch_valid(lv_b)
  );

  bcd_gate_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_one (
    .sigin(sigin), .clear(clear), .w_enable(w_enable),
    .count_bcd(cnt_c), .overflow(ovf_c), .latch_bcd(lat_c), .latch_ovf(lovf_c),
    .latch_valid(lv_c)
  );

  logic [15:0] obs_cnt [3];
  logic [15:0] obs_lat [3];
  logic        obs_ovf [3];
  logic        obs_lovf [3];
  logic        obs_lv [3];

  assign obs_cnt[0] = cnt_a;
  assign obs_cnt[1] = cnt_b;
  assign obs_cnt[2] = {12'h000, cnt_c};
  assign obs_lat[0] = lat_a;
  assign obs_lat[1] = lat_b;
  assign obs_lat[2] = {12'h000, lat_c};
  assign obs_ovf[0] = ovf_a;
  assign obs_ovf[1] = ovf_b;
  assign obs_ovf[2] = ovf_c;
  assign obs_lovf[0] = lovf_a;
  assign obs_lovf[1] = lovf_b;
  assign obs_lovf[2] = lovf_c;
  assign obs_lv[0] = lv_a;
  assign obs_lv[1] = lv_b;
  assign obs_lv[2] = lv_c;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: edges counted in the current window and the count held at the last close.
  int win_n   = 0;
  int held_n  = 0;
  bit held_v  = 1'b0;
  bit en_prev = 1'b0;

  function automatic int modulus(input int k);
    return (k == 2) ? 10 : 10000;
  endfunction

  // What an instance displays after n counted edges.
  function automatic int shown(input int n, input int k);
    int m;
    m = modulus(k);
    if (k == 1) return (n >= m) ? m - 1 : n;
    return n % m;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("count[%0d]", k), obs_cnt[k], to_bcd(shown(win_n, k)));
      check_eq($sformatf("overflow[%0d]", k), obs_ovf[k], win_n >= modulus(k));
      check_eq($sformatf("latch_bcd[%0d]", k), obs_lat[k], to_bcd(shown(held_n, k)));
      check_eq($sformatf("latch_ovf[%0d]", k), obs_lovf[k], held_n >= modulus(k));
      check_eq($sformatf("latch_valid[%0d]", k), obs_lv[k], held_v);
    end
  endtask

  task automatic step(input bit w, input bit c);
    @(negedge sigin);
    w_enable = w;
    clear    = c;
    @(posedge sigin);
    if (c) begin
      win_n   = 0;
      held_n  = 0;
      held_v  = 1'b0;
      en_prev = 1'b0;
    end else begin
      if (w && !en_prev) begin
        win_n  = 1;
        held_v = 1'b0;
      end else if (w) begin
        win_n++;
        held_v = 1'b0;
      end else if (en_prev) begin
        held_n = win_n;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      en_prev = w;
    end
    #1;
    compare_all();
  endtask

  task automatic gate_on(input int len);
    for (int i = 0; i < len; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    // Reset state.
    step(1'b0, 1'b1);
    check_eq("rst_count", cnt_a, 16'h0000);
    check_eq("rst_latch", lat_a, 16'h0000);
    check_eq("rst_valid", lv_a, 1'b0);

    // Basic 37-edge window.
    gate_on(37);
    step(1'b0, 1'b0);
    check_eq("basic_latch", lat_a, 16'h0037);
    check_eq("basic_valid", lv_a, 1'b1);
    check_eq("basic_lovf", lovf_a, 1'b0);
    step(1'b0, 1'b0);
    check_eq("basic_valid_drop", lv_a, 1'b0);
    check_eq("basic_count_hold", cnt_a, 16'h0037);

    // Ripple carry through 0999 -> 1000.
    gate_on(999);
    check_eq("ripple_0999", cnt_a, 16'h0999);
    step(1'b1, 1'b0);
    check_eq("ripple_1000", cnt_a, 16'h1000);
    step(1'b0, 1'b0);
    check_eq("ripple_latch", lat_a, 16'h1000);

    // Overflow past all-9s.
    step(1'b0, 1'b0);
    gate_on(10003);
    step(1'b0, 1'b0);
    check_eq("wrap_latch", lat_a, 16'h0003);
    check_eq("wrap_lovf", lovf_a, 1'b1);
    check_eq("sat_latch", lat_b, 16'h9999);
    check_eq("sat_lovf", lovf_b, 1'b1);

    // Consecutive windows separated by three idle edges.
    step(1'b0, 1'b0);
    gate_on(37);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    gate_on(5);
    check_eq("consec_hold", lat_a, 16'h0037);
    step(1'b0, 1'b0);
    check_eq("consec_latch", lat_a, 16'h0005);
    check_eq("consec_lovf", lovf_a, 1'b0);

    // Clear on edge 20 of an open window, then 10 more gated edges.
    step(1'b0, 1'b0);
    gate_on(19);
    step(1'b1, 1'b1);
    gate_on(10);
    step(1'b0, 1'b0);
    check_eq("clr_mid_latch", lat_a, 16'h0010);

    // Clear on the close edge cancels the latch.
    step(1'b0, 1'b0);
    gate_on(7);
    step(1'b0, 1'b1);
    check_eq("clr_close_valid", lv_a, 1'b0);
    check_eq("clr_close_latch", lat_a, 16'h0000);

    // Single-digit counter.
    step(1'b0, 1'b0);
    gate_on(12);
    step(1'b0, 1'b0);
    check_eq("d1_latch12", lat_c, 4'd2);
    check_eq("d1_lovf12", lovf_c, 1'b1);
    gate_on(1);
    step(1'b0, 1'b0);
    check_eq("d1_latch1", lat_c, 4'd1);
    check_eq("d1_lovf1", lovf_c, 1'b0);
    check_eq("single_win_latch", lat_a, 16'h0001);

    // Random windows, gaps (including zero-length gaps that merge) and stray clears.
    for (int it = 0; it < 150; it++) begin
      int len;
      int gap;
      len = int'($urandom_range(1, 250));
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) step(1'b1, ($urandom_range(0, 127) == 0));
      for (int i = 0; i < gap; i++) step(1'b0, ($urandom_range(0, 31) == 0));
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
